// File: rtl/pingpong_wr_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_wr_ctrl
//
// Writer-side controller for a two-bank (ping-pong) feature-map buffer.
// It produces linear write addresses {bank, offset}. It tracks which bank
// is full and owned by the consumer. When both banks are full, it holds
// off the producer.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   clr           synchronous soft clear, same effect as reset
//   wr_valid      producer has a word this cycle
//   wr_ready      current write bank is free to be written
//   wr_en         buffer write strobe for the word at wr_addr
//   wr_addr       linear write address {write bank, offset}
//   rd_bank_valid read bank is full and handed to the consumer
//   rd_bank_id    bank the consumer must read
//   rd_base       linear base address of the read bank
//   rd_done       one-cycle pulse: consumer finished the read bank
//   full_cnt      number of filled banks (0..2)
//   err           sticky flag: rd_done seen with no bank to release
// ---------------------------------------------------------------------------
module pingpong_wr_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int BANK_DEPTH = 256,
  parameter int FILL_LEN   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_bank_valid,
  output logic              rd_bank_id,
  output logic [ADDR_W-1:0] rd_base,
  input  logic              rd_done,
  output logic [1:0]        full_cnt,
  output logic              err
);

  localparam int OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FILL_LEN - 1);

  logic             wb;
  logic             rb;
  logic [OFF_W-1:0] off;
  logic [1:0]       filled;

  logic             wb_nxt;
  logic             rb_nxt;
  logic [OFF_W-1:0] off_nxt;
  logic [1:0]       filled_nxt;
  logic             err_nxt;

  logic             accept;
  logic             fill_done;
  logic             release_bank;
  logic             bad_done;

  // The write strobe is suppressed while a clear is pending, because the
  // clear discards the partial bank anyway. It is also suppressed while
  // reset is held low, so a held wr_valid cannot write into the buffer
  // during reset.
  assign wr_ready      = ~filled[wb];
  assign accept        = wr_valid & wr_ready & ~clr & rst_n;
  assign wr_en         = accept;
  assign wr_addr       = {wb, off};
  assign rd_bank_valid = filled[rb];
  assign rd_bank_id    = rb;
  assign rd_base       = rb ? ADDR_W'(BANK_DEPTH) : '0;
  assign full_cnt      = {1'b0, filled[0]} + {1'b0, filled[1]};

  assign fill_done     = accept & (off == LAST_OFF);
  assign release_bank  = rd_done & filled[rb];
  assign bad_done      = rd_done & ~filled[rb];

  // Next-state logic. A fill completion and a release can happen in the
  // same cycle. They never touch the same bank: a fill needs filled[wb]=0,
  // and a release needs filled[rb]=1. So both updates are applied
  // independently. The soft clear overrides everything else.
  always_comb begin
    wb_nxt     = wb;
    rb_nxt     = rb;
    off_nxt    = off;
    filled_nxt = filled;
    err_nxt    = err;
    if (clr) begin
      wb_nxt     = 1'b0;
      rb_nxt     = 1'b0;
      off_nxt    = '0;
      filled_nxt = 2'b00;
      err_nxt    = 1'b0;
    end else begin
      if (accept) begin
        if (fill_done) begin
          off_nxt        = '0;
          filled_nxt[wb] = 1'b1;
          wb_nxt         = ~wb;
        end else begin
          off_nxt = off + 1'b1;
        end
      end
      if (release_bank) begin
        filled_nxt[rb] = 1'b0;
        rb_nxt         = ~rb;
      end
      if (bad_done) begin
        err_nxt = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb     <= 1'b0;
      rb     <= 1'b0;
      off    <= '0;
      filled <= 2'b00;
      err    <= 1'b0;
    end else begin
      wb     <= wb_nxt;
      rb     <= rb_nxt;
      off    <= off_nxt;
      filled <= filled_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_wr_ctrl
//
// Self-checking bench for pingpong_wr_ctrl. There are two instances:
//   dut  - default configuration (FILL_LEN=256)
//   dutb - short fill (FILL_LEN=100), used for early handover and
//          asynchronous reset in the middle of a fill
// Expected write addresses go into a queue when a write is driven. They are
// popped and compared when the DUT strobes the write. A small behavioural
// model of bank ownership gives the expected status outputs.
// ---------------------------------------------------------------------------
module tb_pingpong_wr_ctrl;

  localparam int ADDR_W = 9;
  localparam int FILL_A = 256;
  localparam int FILL_B = 100;

  logic clk = 1'b0;

  logic              rst_n, clr, wr_valid, rd_done;
  logic              wr_ready, wr_en, rd_bank_valid, rd_bank_id, err;
  logic [ADDR_W-1:0] wr_addr, rd_base;
  logic [1:0]        full_cnt;

  logic              rst_n_b, clr_b, wr_valid_b, rd_done_b;
  logic              wr_ready_b, wr_en_b, rd_bank_valid_b, rd_bank_id_b, err_b;
  logic [ADDR_W-1:0] wr_addr_b, rd_base_b;
  logic [1:0]        full_cnt_b;

  int checks   = 0;
  int failures = 0;

  int addr_q[$];
  int addr_q_b[$];

  int m_wb, m_rb, m_off, m_err;
  int m_filled[2];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  pingpong_wr_ctrl #(.ADDR_W(ADDR_W), .BANK_DEPTH(256), .FILL_LEN(FILL_A)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_bank_valid(rd_bank_valid), .rd_bank_id(rd_bank_id), .rd_base(rd_base),
    .rd_done(rd_done), .full_cnt(full_cnt), .err(err)
  );

  pingpong_wr_ctrl #(.ADDR_W(ADDR_W), .BANK_DEPTH(256), .FILL_LEN(FILL_B)) dutb (
    .clk(clk), .rst_n(rst_n_b), .clr(clr_b), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .rd_bank_valid(rd_bank_valid_b), .rd_bank_id(rd_bank_id_b), .rd_base(rd_base_b),
    .rd_done(rd_done_b), .full_cnt(full_cnt_b), .err(err_b)
  );

  // Compares one observed value against its expected value, counts the
  // comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_wb = 0; m_rb = 0; m_off = 0; m_err = 0;
    m_filled[0] = 0; m_filled[1] = 0;
    addr_q.delete();
  endtask

  // Compares every status output of the main instance with the model.
  // Pops the scoreboard when the model expects a write this cycle.
  task automatic checkState(input int acc);
    int exp_addr;
    checkOutput("wr_en", {31'd0, wr_en}, acc);
    checkOutput("wr_ready", {31'd0, wr_ready}, (m_filled[m_wb] == 0) ? 1 : 0);
    if (acc != 0) begin
      if (addr_q.size() == 0) begin
        checkOutput("scoreboard_empty", 1, 0);
      end else begin
        exp_addr = addr_q.pop_front();
        checkOutput("wr_addr", {23'd0, wr_addr}, exp_addr);
      end
    end else begin
      checkOutput("wr_addr_hold", {23'd0, wr_addr}, m_wb * 256 + m_off);
    end
    checkOutput("rd_bank_valid", {31'd0, rd_bank_valid}, m_filled[m_rb]);
    checkOutput("rd_bank_id", {31'd0, rd_bank_id}, m_rb);
    checkOutput("rd_base", {23'd0, rd_base}, m_rb * 256);
    checkOutput("full_cnt", {30'd0, full_cnt}, m_filled[0] + m_filled[1]);
    checkOutput("err", {31'd0, err}, m_err);
  endtask

  // Drives one cycle of stimulus on the main instance. It is entered just
  // after a rising edge. It checks the outputs on the falling edge, then
  // advances the model on the next rising edge. Release is decided from
  // the pre-edge state, so a fill in the same cycle cannot affect it.
  task automatic applyStimulus(input logic v, input logic d, input logic c);
    int acc, rel;
    wr_valid = v; rd_done = d; clr = c;
    acc = (v && m_filled[m_wb] == 0 && !c) ? 1 : 0;
    rel = (d && m_filled[m_rb] == 1) ? 1 : 0;
    if (acc != 0) addr_q.push_back(m_wb * 256 + m_off);
    @(negedge clk);
    checkState(acc);
    @(posedge clk);
    if (c) begin
      modelReset();
    end else begin
      if (acc != 0) begin
        if (m_off == FILL_A - 1) begin
          m_filled[m_wb] = 1;
          m_wb  = 1 - m_wb;
          m_off = 0;
        end else begin
          m_off++;
        end
      end
      if (d) begin
        if (rel != 0) begin
          m_filled[m_rb] = 0;
          m_rb = 1 - m_rb;
        end else begin
          m_err = 1;
        end
      end
    end
    #1;
  endtask

  // Drives one write on the short-fill instance and checks its strobe and
  // address through the second scoreboard.
  task automatic writeB(input int exp_addr);
    int popped;
    wr_valid_b = 1'b1;
    addr_q_b.push_back(exp_addr);
    @(negedge clk);
    checkOutput("b_wr_en", {31'd0, wr_en_b}, 1);
    popped = addr_q_b.pop_front();
    checkOutput("b_wr_addr", {23'd0, wr_addr_b}, popped);
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; rd_done = 1'b0;
    rst_n_b = 1'b0; clr_b = 1'b0; wr_valid_b = 1'b0; rd_done_b = 1'b0;
    modelReset();

    // Reset state, and no strobe while reset is held low.
    #12;
    wr_valid = 1'b1;
    #1;
    checkOutput("rst_wr_en", {31'd0, wr_en}, 0);
    checkOutput("rst_wr_ready", {31'd0, wr_ready}, 1);
    checkOutput("rst_wr_addr", {23'd0, wr_addr}, 0);
    checkOutput("rst_rd_bank_valid", {31'd0, rd_bank_valid}, 0);
    checkOutput("rst_rd_base", {23'd0, rd_base}, 0);
    checkOutput("rst_full_cnt", {30'd0, full_cnt}, 0);
    checkOutput("rst_err", {31'd0, err}, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill bank 0, then check the handover.
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("h0_rd_bank_valid", {31'd0, rd_bank_valid}, 1);
    checkOutput("h0_rd_bank_id", {31'd0, rd_bank_id}, 0);
    checkOutput("h0_rd_base", {23'd0, rd_base}, 0);
    checkOutput("h0_wr_addr", {23'd0, wr_addr}, 256);
    checkOutput("h0_full_cnt", {30'd0, full_cnt}, 1);

    // Fill bank 1 without a release, then stall with wr_valid held.
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("full_wr_ready", {31'd0, wr_ready}, 0);
    checkOutput("full_full_cnt", {30'd0, full_cnt}, 2);
    checkOutput("full_wr_addr", {23'd0, wr_addr}, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    // Release from both-full, then one write lands at address 0.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rel_rd_bank_id", {31'd0, rd_bank_id}, 1);
    checkOutput("rel_rd_base", {23'd0, rd_base}, 256);
    checkOutput("rel_wr_ready", {31'd0, wr_ready}, 1);
    checkOutput("rel_full_cnt", {30'd0, full_cnt}, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Finish bank 0, release bank 1, then fill bank 1 with its last word
    // written in the same cycle as the release of bank 0.
    for (int i = 0; i < 255; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("sim_full_cnt", {30'd0, full_cnt}, 1);
    checkOutput("sim_rd_bank_id", {31'd0, rd_bank_id}, 1);
    checkOutput("sim_rd_bank_valid", {31'd0, rd_bank_valid}, 1);
    checkOutput("sim_wr_addr", {23'd0, wr_addr}, 0);
    checkOutput("sim_err", {31'd0, err}, 0);

    // Drain, then send a spurious rd_done; err is sticky until clr.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("err_set", {31'd0, err}, 1);
    checkOutput("err_full_cnt", {30'd0, full_cnt}, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("err_sticky", {31'd0, err}, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_err", {31'd0, err}, 0);
    checkOutput("clr_wr_addr", {23'd0, wr_addr}, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    wr_valid = 1'b0;

    // Short-fill instance: handover after 100 words.
    @(negedge clk);
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < FILL_B; i++) writeB(i);
    checkOutput("b_h0_wr_addr", {23'd0, wr_addr_b}, 256);
    checkOutput("b_h0_rd_bank_valid", {31'd0, rd_bank_valid_b}, 1);
    checkOutput("b_h0_full_cnt", {30'd0, full_cnt_b}, 1);

    // Asynchronous reset in the middle of the second fill.
    for (int i = 0; i < 50; i++) writeB(256 + i);
    wr_valid_b = 1'b1;
    #2;
    rst_n_b = 1'b0;
    #1;
    checkOutput("b_arst_wr_addr", {23'd0, wr_addr_b}, 0);
    checkOutput("b_arst_wr_en", {31'd0, wr_en_b}, 0);
    checkOutput("b_arst_full_cnt", {30'd0, full_cnt_b}, 0);
    checkOutput("b_arst_rd_bank_valid", {31'd0, rd_bank_valid_b}, 0);
    wr_valid_b = 1'b0;
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
